// File: rtl/out_port.sv
// Router output stage: round-robin selects one credited VC flit per cycle onto the link.
// Latency: grant is combinational; the selected flit appears on flit_out one cycle later.
// Backpressure: a VC with zero downstream credits is skipped until a credit pulse returns.

`ifndef FLIT_SIZE
`define FLIT_SIZE 16
`endif
`ifndef FLIT_VC
`define FLIT_VC (`FLIT_SIZE-1):(`FLIT_SIZE-3)
`endif

module out_port #(
  parameter int VC_NUM       = 4,
  parameter int BUFFER_DEPTH = 4,
  parameter int CNT_W        = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [`FLIT_SIZE*VC_NUM-1:0]  flit_in,
  input  logic [VC_NUM-1:0]             flit_valid,
  input  logic [VC_NUM-1:0]             credit_next_router,
  output logic [VC_NUM-1:0]             grant,
  output logic [`FLIT_SIZE-1:0]         flit_out,
  output logic [CNT_W*VC_NUM-1:0]       credit_cnt,
  output logic                          credit_err
);

  localparam logic [CNT_W-1:0] DEPTH   = CNT_W'(BUFFER_DEPTH);
  localparam logic [3:0]       VC_NUM4 = 4'(VC_NUM);
  localparam logic [2:0]       VC_LAST = 3'(VC_NUM - 1);

  logic [CNT_W-1:0]      cnt_q [VC_NUM];
  logic [2:0]            rr_ptr_q;
  logic [`FLIT_SIZE-1:0] flit_out_q;
  logic                  credit_err_q;

  // Eligibility padded to 8 entries so the 3-bit VC index addresses it exactly.
  logic [7:0]            eligible;
  logic                  win_found;
  logic [2:0]            win_idx;
  logic [`FLIT_SIZE-1:0] flit_sel_d;

  // A VC may compete only when it has a flit and at least one downstream slot.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      eligible[i] = flit_valid[i] && (cnt_q[i] != '0);
    end
  end

  // Round-robin search starting at the pointer, wrapping at VC_NUM.
  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    idx       = '0;
    for (int off = 0; off < VC_NUM; off++) begin
      sum = {1'b0, rr_ptr_q} + 4'(off);
      if (sum >= VC_NUM4) begin
        sum = sum - VC_NUM4;
      end
      idx = sum[2:0];
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Pop strobe to upstream; suppressed while reset is asserted.
  always_comb begin
    grant = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      grant[i] = win_found && !reset && (win_idx == 3'(i));
    end
  end

  // Winning flit with its VC field rewritten to the winner's index.
  always_comb begin
    flit_sel_d = '1;
    for (int i = 0; i < VC_NUM; i++) begin
      if (win_found && (win_idx == 3'(i))) begin
        flit_sel_d = flit_in[i*`FLIT_SIZE +: `FLIT_SIZE];
      end
    end
    flit_sel_d[`FLIT_VC] = win_found ? win_idx : 3'd7;
  end

  // Link register and round-robin pointer advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      flit_out_q <= '1;
      rr_ptr_q   <= '0;
    end else begin
      flit_out_q <= win_found ? flit_sel_d : '1;
      if (win_found) begin
        rr_ptr_q <= (win_idx == VC_LAST) ? 3'd0 : win_idx + 3'd1;
      end
    end
  end

  // Per-VC credit counters; a credit into a full counter saturates and flags an error.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < VC_NUM; i++) begin
        cnt_q[i] <= DEPTH;
      end
      credit_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < VC_NUM; i++) begin
        case ({credit_next_router[i], grant[i]})
          2'b10: begin
            if (cnt_q[i] == DEPTH) begin
              credit_err_q <= 1'b1;
            end else begin
              cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
          end
          2'b01:   cnt_q[i] <= cnt_q[i] - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Flatten counters for monitoring.
  always_comb begin
    credit_cnt = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      credit_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign flit_out   = flit_out_q;
  assign credit_err = credit_err_q;

endmodule

// File: tb/tb_out_port.sv
// Bench for out_port: directed stimulus, cycle-by-cycle reference model plus literal spot checks.
// Model advances on each rising edge; compare process samples on the falling edge.
// Inputs change 2 time units after the rising edge so the model sees stable values.

module tb_out_port;
  localparam int VC = 4;
  localparam int FS = 16;
  localparam int DEPTH = 4;

  logic              clock;
  logic              reset;
  logic [FS*VC-1:0]  flit_in;
  logic [VC-1:0]     flit_valid;
  logic [VC-1:0]     credit_next_router;
  logic [VC-1:0]     grant;
  logic [FS-1:0]     flit_out;
  logic [3*VC-1:0]   credit_cnt;
  logic              credit_err;

  int total = 0;
  int bad   = 0;

  out_port #(.VC_NUM(VC), .BUFFER_DEPTH(DEPTH), .CNT_W(3)) dut (
    .clock              (clock),
    .reset              (reset),
    .flit_in            (flit_in),
    .flit_valid         (flit_valid),
    .credit_next_router (credit_next_router),
    .grant              (grant),
    .flit_out           (flit_out),
    .credit_cnt         (credit_cnt),
    .credit_err         (credit_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int          m_cnt [VC];
  int          m_ptr;
  logic [FS-1:0] m_flit;
  logic        m_err;
  bit          m_ready = 0;

  function automatic int pick();
    for (int off = 0; off < VC; off++) begin
      int k;
      k = (m_ptr + off) % VC;
      if (flit_valid[k] && m_cnt[k] > 0) return k;
    end
    return -1;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < VC; i++) m_cnt[i] = DEPTH;
      m_ptr   = 0;
      m_flit  = '1;
      m_err   = 1'b0;
      m_ready = 1;
    end else if (m_ready) begin
      int w;
      w = pick();
      if (w >= 0) begin
        m_flit = flit_in[w*FS +: FS];
        m_flit[FS-1 -: 3] = 3'(w);
        m_ptr = (w + 1) % VC;
      end else begin
        m_flit = '1;
      end
      for (int i = 0; i < VC; i++) begin
        int inc, dec;
        inc = credit_next_router[i] ? 1 : 0;
        dec = (i == w) ? 1 : 0;
        if (inc == 1 && dec == 0 && m_cnt[i] == DEPTH) m_err = 1'b1;
        else m_cnt[i] = m_cnt[i] + inc - dec;
      end
    end
  end

  // Compare process: every falling edge once the model has been reset.
  always @(negedge clock) begin
    if (m_ready) begin
      int w;
      logic [VC-1:0] eg;
      w  = pick();
      eg = (reset || w < 0) ? '0 : VC'(1 << w);
      chk("grant", 32'(grant), 32'(eg));
      chk("flit_out", 32'(flit_out), 32'(m_flit));
      chk("credit_err", 32'(credit_err), 32'(m_err));
      for (int i = 0; i < VC; i++) begin
        chk($sformatf("credit_cnt[%0d]", i), 32'(credit_cnt[i*3 +: 3]), 32'(m_cnt[i]));
      end
    end
  end

  task automatic step(input logic r, input logic [VC-1:0] v, input logic [VC-1:0] c);
    @(posedge clock);
    #2;
    reset = r;
    flit_valid = v;
    credit_next_router = c;
  endtask

  initial begin
    reset = 1'b1;
    flit_valid = '0;
    credit_next_router = '0;
    // VC3..VC0; top 3 bits deliberately wrong so the VC rewrite is visible
    flit_in = {16'hF344, 16'h0233, 16'hC122, 16'hE011};

    // Reset then idle
    step(1, 4'b0000, 4'b0000);
    step(1, 4'b0000, 4'b0000);
    repeat (5) step(0, 4'b0000, 4'b0000);
    #1;
    chk("idle_cnt", 32'(credit_cnt), 32'h924);
    chk("idle_flit", 32'(flit_out), 32'hFFFF);
    chk("idle_err", 32'(credit_err), 32'h0);
    chk("idle_grant", 32'(grant), 32'h0);

    // All VCs valid, no credits returned: drain 16 grants
    step(0, 4'b1111, 4'b0000);
    #1 chk("rr_first", 32'(grant), 32'h1);
    step(0, 4'b1111, 4'b0000);
    #1 chk("rr_second", 32'(grant), 32'h2);
    chk("rr_flit_vc0", 32'(flit_out), 32'h0011);
    step(0, 4'b1111, 4'b0000);
    #1 chk("rr_flit_vc1", 32'(flit_out), 32'h2122);
    repeat (17) step(0, 4'b1111, 4'b0000);
    #1;
    chk("drain_cnt", 32'(credit_cnt), 32'h0);
    chk("drain_grant", 32'(grant), 32'h0);
    chk("drain_flit", 32'(flit_out), 32'hFFFF);

    // VC2 alone: drain, then a single credit revives it
    step(1, 4'b0000, 4'b0000);
    repeat (5) step(0, 4'b0100, 4'b0000);
    #1 chk("vc2_blocked", 32'(grant), 32'h0);
    step(0, 4'b0100, 4'b0100);
    #1 chk("vc2_credit_cycle", 32'(grant), 32'h0);
    step(0, 4'b0100, 4'b0000);
    #1 chk("vc2_regrant", 32'(grant), 32'h4);
    step(0, 4'b0000, 4'b0000);
    #1;
    chk("vc2_flit", 32'(flit_out), 32'h4233);
    chk("vc2_cnt", 32'(credit_cnt[8:6]), 32'h0);

    // VC1 at one credit: simultaneous grant and credit keeps it at one
    step(1, 4'b0000, 4'b0000);
    repeat (3) step(0, 4'b0010, 4'b0000);
    step(0, 4'b0010, 4'b0010);
    #1 chk("vc1_grant_inc", 32'(grant), 32'h2);
    step(0, 4'b0010, 4'b0000);
    #1;
    chk("vc1_cnt_hold", 32'(credit_cnt[5:3]), 32'h1);
    chk("vc1_grant_again", 32'(grant), 32'h2);
    step(0, 4'b0000, 4'b0000);
    #1 chk("vc1_cnt_zero", 32'(credit_cnt[5:3]), 32'h0);

    // VC3 full: grant and credit together leave it full without error
    step(0, 4'b1000, 4'b1000);
    #1 chk("vc3_grant", 32'(grant), 32'h8);
    step(0, 4'b0000, 4'b0000);
    #1;
    chk("vc3_cnt", 32'(credit_cnt[11:9]), 32'h4);
    chk("vc3_no_err", 32'(credit_err), 32'h0);

    // Credit into a full counter: saturate and raise sticky error
    step(0, 4'b0000, 4'b0001);
    step(0, 4'b0000, 4'b0000);
    #1;
    chk("ovf_err", 32'(credit_err), 32'h1);
    chk("ovf_cnt", 32'(credit_cnt[2:0]), 32'h4);
    repeat (3) step(0, 4'b0000, 4'b0000);
    #1 chk("ovf_sticky", 32'(credit_err), 32'h1);

    // Reset while VC0 and VC3 stream
    step(1, 4'b0000, 4'b0000);
    repeat (3) step(0, 4'b1001, 4'b0000);
    step(1, 4'b1001, 4'b0000);
    #1 chk("rst_grant_low", 32'(grant), 32'h0);
    step(0, 4'b1001, 4'b0000);
    #1;
    chk("rst_flit", 32'(flit_out), 32'hFFFF);
    chk("rst_cnt", 32'(credit_cnt), 32'h924);
    chk("rst_err", 32'(credit_err), 32'h0);
    chk("rst_first_grant", 32'(grant), 32'h1);
    step(0, 4'b0000, 4'b0000);
    #1 chk("rst_first_flit", 32'(flit_out), 32'h0011);
    step(0, 4'b0000, 4'b0000);

    @(posedge clock);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
